clint_timer: RTL and testbench



---
 rtl/clint_timer.sv | 147 ++++++++++++++
 tb/tb_clint_timer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime with prescaler, mtimecmp compare, msip soft-interrupt bit.
// Latency: one-cycle registered response; register writes land at the accept edge.
// Backpressure: one-deep response slot; the request port stalls only while a response is held.
module clint_timer #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_we,
    input  logic [31:0]       i_req_wdata,
    input  logic [3:0]        i_req_wmask,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err,
    output logic [63:0]       o_mtime,
    output logic              o_int_timer,
    output logic              o_int_soft
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [ADDR_W-1:0] A_MSIP    = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] A_CMP_LO  = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] A_CMP_HI  = ADDR_W'(16'h4004);
    localparam logic [ADDR_W-1:0] A_TIME_LO = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] A_TIME_HI = ADDR_W'(16'hBFFC);

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          int_timer_q, int_timer_d;
    logic          resp_vld_q, resp_vld_d;
    resp_t         resp_q, resp_d;

    logic        tick;
    logic        accept;
    logic        wr_en;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic        addr_err;
    logic [31:0] rd_val;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wr_val,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = wr_val[8*b +: 8];
        end
        return r;
    endfunction

    assign o_req_ready = !resp_vld_q || i_resp_ready;

    always_comb begin
        presc_d     = presc_q;
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        resp_vld_d  = resp_vld_q;
        resp_d      = resp_q;
        int_timer_d = (mtime_q >= mtimecmp_q);
        rd_val      = 32'd0;

        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;

        sel_msip    = (i_req_addr == A_MSIP);
        sel_cmp_lo  = (i_req_addr == A_CMP_LO);
        sel_cmp_hi  = (i_req_addr == A_CMP_HI);
        sel_time_lo = (i_req_addr == A_TIME_LO);
        sel_time_hi = (i_req_addr == A_TIME_HI);
        addr_err    = !(sel_msip || sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi);

        if (sel_msip)    rd_val = {31'd0, msip_q};
        if (sel_cmp_lo)  rd_val = mtimecmp_q[31:0];
        if (sel_cmp_hi)  rd_val = mtimecmp_q[63:32];
        if (sel_time_lo) rd_val = mtime_q[31:0];
        if (sel_time_hi) rd_val = mtime_q[63:32];

        accept = i_req_valid && o_req_ready;
        // An all-zero mask is a no-op and must not suppress the tick on mtime.
        wr_en  = accept && i_req_we && !addr_err && (i_req_wmask != 4'd0);

        if (tick) mtime_d = mtime_q + 64'd1;
        if (wr_en && sel_time_lo)
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_req_wdata, i_req_wmask)};
        // A hi write keeps the lo increment but drops its carry into hi.
        if (wr_en && sel_time_hi)
            mtime_d = {merge_bytes(mtime_q[63:32], i_req_wdata, i_req_wmask),
                       mtime_q[31:0] + {31'd0, tick}};
        if (wr_en && sel_cmp_lo)
            mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], i_req_wdata, i_req_wmask);
        if (wr_en && sel_cmp_hi)
            mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], i_req_wdata, i_req_wmask);
        if (wr_en && sel_msip && i_req_wmask[0])
            msip_d = i_req_wdata[0];

        if (accept) begin
            resp_vld_d   = 1'b1;
            resp_d.rdata = (i_req_we || addr_err) ? 32'd0 : rd_val;
            resp_d.err   = addr_err;
        end else if (i_resp_ready) begin
            resp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q     <= '0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            int_timer_q <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_q      <= '0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            int_timer_q <= int_timer_d;
            resp_vld_q  <= resp_vld_d;
            resp_q      <= resp_d;
        end
    end

    assign o_resp_valid = resp_vld_q;
    assign o_resp_rdata = resp_q.rdata;
    assign o_resp_err   = resp_q.err;
    assign o_mtime      = mtime_q;
    assign o_int_timer  = int_timer_q;
    assign o_int_soft   = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV 4 and 1) share one request stream;
// a per-instance reference model feeds expected responses to a scoreboard monitor.
module tb_clint_timer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_ready;

    logic [1:0]  rdy, rv, err, itim, isoft;
    logic [31:0] rdata   [2];
    logic [63:0] mtime_o [2];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    logic        m_rv    [2];
    logic        m_int   [2];
    int          m_presc [2];
    int          tdiv    [2] = '{4, 1};

    logic        stall_prev [2];
    logic [31:0] held_rdata [2];
    logic        held_err   [2];

    logic [15:0] addrs [9] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
                               16'h0008, 16'h4002, 16'hBFF9, 16'h1234};

    int n_checks = 0;
    int n_fail   = 0;

    clint_timer #(.TICK_DIV(4), .ADDR_W(16)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy[0]),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata),
        .i_req_wmask(req_wmask), .o_resp_valid(rv[0]), .i_resp_ready(resp_ready),
        .o_resp_rdata(rdata[0]), .o_resp_err(err[0]), .o_mtime(mtime_o[0]),
        .o_int_timer(itim[0]), .o_int_soft(isoft[0])
    );

    clint_timer #(.TICK_DIV(1), .ADDR_W(16)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(rdy[1]),
        .i_req_addr(req_addr), .i_req_we(req_we), .i_req_wdata(req_wdata),
        .i_req_wmask(req_wmask), .o_resp_valid(rv[1]), .i_resp_ready(resp_ready),
        .o_resp_rdata(rdata[1]), .o_resp_err(err[1]), .o_mtime(mtime_o[1]),
        .o_int_timer(itim[1]), .o_int_soft(isoft[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input int k, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got %h expected %h", name, k, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Reference model: one step per clock edge, straight from the register-map rules.
    task automatic model_step(input int k);
        logic        ready_now, tick, acc, e_err, int_next;
        logic [31:0] rd;
        logic [63:0] nt;
        exp_t        e;
        if (!rst_n) begin
            m_mtime[k] = 64'd0;
            m_cmp[k]   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip[k]  = 1'b0;
            m_rv[k]    = 1'b0;
            m_int[k]   = 1'b0;
            m_presc[k] = 0;
            if (k == 0) q0.delete(); else q1.delete();
            return;
        end
        ready_now = !m_rv[k] || resp_ready;
        tick      = (m_presc[k] == tdiv[k] - 1);
        int_next  = (m_mtime[k] >= m_cmp[k]);
        nt        = tick ? m_mtime[k] + 64'd1 : m_mtime[k];
        acc       = req_valid && ready_now;
        if (acc) begin
            e_err = 1'b0;
            rd    = 32'd0;
            case (req_addr)
                16'h0000: rd = {31'd0, m_msip[k]};
                16'h4000: rd = m_cmp[k][31:0];
                16'h4004: rd = m_cmp[k][63:32];
                16'hBFF8: rd = m_mtime[k][31:0];
                16'hBFFC: rd = m_mtime[k][63:32];
                default:  e_err = 1'b1;
            endcase
            e.rdata = (req_we || e_err) ? 32'd0 : rd;
            e.err   = e_err;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
            if (req_we && !e_err && req_wmask != 4'd0) begin
                case (req_addr)
                    16'h0000: if (req_wmask[0]) m_msip[k] = req_wdata[0];
                    16'h4000: m_cmp[k][31:0]  = merge(m_cmp[k][31:0], req_wdata, req_wmask);
                    16'h4004: m_cmp[k][63:32] = merge(m_cmp[k][63:32], req_wdata, req_wmask);
                    16'hBFF8: nt = {m_mtime[k][63:32], merge(m_mtime[k][31:0], req_wdata, req_wmask)};
                    16'hBFFC: nt = {merge(m_mtime[k][63:32], req_wdata, req_wmask),
                                    m_mtime[k][31:0] + (tick ? 32'd1 : 32'd0)};
                    default: ;
                endcase
            end
        end
        m_mtime[k] = nt;
        m_rv[k]    = acc ? 1'b1 : (resp_ready ? 1'b0 : m_rv[k]);
        m_presc[k] = tick ? 0 : m_presc[k] + 1;
        m_int[k]   = int_next;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        for (int k = 0; k < 2; k++) stall_prev[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    check(k, "rst_resp_valid", 64'(rv[k]), 64'd0);
                    check(k, "rst_mtime", mtime_o[k], 64'd0);
                    check(k, "rst_int_timer", 64'(itim[k]), 64'd0);
                    check(k, "rst_int_soft", 64'(isoft[k]), 64'd0);
                    check(k, "rst_req_ready", 64'(rdy[k]), 64'd1);
                    stall_prev[k] = 1'b0;
                end else begin
                    check(k, "mtime", mtime_o[k], m_mtime[k]);
                    check(k, "int_timer", 64'(itim[k]), 64'(m_int[k]));
                    check(k, "int_soft", 64'(isoft[k]), 64'(m_msip[k]));
                    check(k, "resp_valid", 64'(rv[k]), 64'(m_rv[k]));
                    check(k, "req_ready", 64'(rdy[k]), 64'(!m_rv[k] || resp_ready));
                    if (stall_prev[k] && rv[k]) begin
                        check(k, "stall_rdata_stable", 64'(rdata[k]), 64'(held_rdata[k]));
                        check(k, "stall_err_stable", 64'(err[k]), 64'(held_err[k]));
                    end
                    if (rv[k] && resp_ready) begin
                        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_response (inst %0d): rdata %h with empty queue",
                                     k, rdata[k]);
                        end else begin
                            e = (k == 0) ? q0.pop_front() : q1.pop_front();
                            check(k, "resp_rdata", 64'(rdata[k]), 64'(e.rdata));
                            check(k, "resp_err", 64'(err[k]), 64'(e.err));
                        end
                    end
                    stall_prev[k] = rv[k] && !resp_ready;
                    held_rdata[k] = rdata[k];
                    held_err[k]   = err[k];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic req(input logic [15:0] a, input logic we, input logic [31:0] d,
                       input logic [3:0] m);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = d;
        req_wmask = m;
        while (m_rv[0] && !resp_ready) begin
            if (n >= 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_accept_timeout: addr %h not accepted in 50 cycles", a);
                break;
            end
            step();
            n++;
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        req(a, 1'b1, d, 4'hF);
    endtask

    task automatic rd(input logic [15:0] a);
        req(a, 1'b0, 32'd0, 4'h0);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 16'd0;
        req_we     = 1'b0;
        req_wdata  = 32'd0;
        req_wmask  = 4'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset.
        repeat (40) step();
        check(0, "idle_mtime_div4", mtime_o[0], 64'd10);
        check(1, "idle_mtime_div1", mtime_o[1], 64'd40);
        check(0, "idle_int_timer", 64'(itim[0]), 64'd0);
        check(0, "idle_int_soft", 64'(isoft[0]), 64'd0);
        check(0, "idle_req_ready", 64'(rdy[0]), 64'd1);

        // Timer interrupt rise and fall.
        wr(16'h4004, 32'd0);
        wr(16'h4000, 32'd5);
        wr(16'hBFFC, 32'd0);
        wr(16'hBFF8, 32'd0);
        n = 0;
        while (mtime_o[1] != 64'd5 && n < 30) begin
            step();
            n++;
        end
        check(1, "wait_mtime_5_in_budget", 64'(n < 30), 64'd1);
        check(1, "timer_before_rise", 64'(itim[1]), 64'd0);
        step();
        check(1, "timer_rise", 64'(itim[1]), 64'd1);
        wr(16'h4000, 32'hFFFF_FFFF);
        step();
        check(1, "timer_fall", 64'(itim[1]), 64'd0);

        // Software interrupt.
        wr(16'h0000, 32'hFFFF_FFFF);
        check(0, "soft_set", 64'(isoft[0]), 64'd1);
        rd(16'h0000);
        wr(16'h0000, 32'd0);
        check(0, "soft_clear", 64'(isoft[0]), 64'd0);

        // 32-bit carry and masked lo write on a tick cycle.
        wr(16'hBFFC, 32'd0);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        check(1, "mtime_lo_written", mtime_o[1], 64'h0000_0000_FFFF_FFFF);
        step();
        check(1, "mtime_carry", mtime_o[1], 64'h0000_0001_0000_0000);
        req(16'hBFF8, 1'b1, 32'h1234_5678, 4'b0011);
        check(1, "mtime_masked_lo", mtime_o[1], 64'h0000_0001_0000_5678);

        // Response stall then back-to-back reads.
        rd(16'hBFF8);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check(0, "stall_req_ready", 64'(rdy[0]), 64'd0);
        end
        resp_ready = 1'b1;
        rd(16'hBFF8);
        rd(16'hBFFC);
        rd(16'h4000);
        rd(16'h4004);
        rd(16'h0000);

        // Error accesses.
        rd(16'h0008);
        req(16'h4002, 1'b1, 32'hDEAD_BEEF, 4'hF);
        rd(16'h4000);
        rd(16'h4004);
        req(16'h4000, 1'b1, 32'h0000_0000, 4'h0);
        rd(16'h4000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_addr   = addrs[$urandom_range(0, 8)];
            req_we     = 1'($urandom_range(0, 1));
            req_wdata  = $urandom;
            req_wmask  = 4'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        repeat (3) step();

        // Reset with a response in flight.
        rd(16'hBFFC);
        resp_ready = 1'b0;
        step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        repeat (8) step();
        rd(16'hBFF8);
        repeat (3) step();
        check(0, "queue_drained", 64'(q0.size() + q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
